// File: rtl/cook_time_countdown_pkg.sv
// Shared types and constants for the cook-time countdown: FSM state encoding and
// BCD limits used by the digit counters and the top-level control.
package cook_time_countdown_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [3:0]  BcdMax         = 4'd9;
    localparam int unsigned SecTensWrapDef = 5;

    function automatic logic bcd_valid(input logic [3:0] d);
        return d <= BcdMax;
    endfunction

endpackage

// File: rtl/cook_time_countdown_if.sv
// Keypad/timebase inputs and display/control outputs of the countdown, bundled so the
// encoder side (master) and the countdown (slave) share one connection.
interface cook_time_countdown_if;

    logic       load;
    logic [3:0] digit;
    logic       pgt_1hz;
    logic       start;
    logic       stop;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;

    modport master (
        output load, digit, pgt_1hz, start, stop,
        input  min_tens, min_ones, sec_tens, sec_ones, running, done
    );

    modport slave (
        input  load, digit, pgt_1hz, start, stop,
        output min_tens, min_ones, sec_tens, sec_ones, running, done
    );

endinterface

// File: rtl/cook_time_countdown_bcd_down_digit.sv
// One BCD digit of the MM:SS count: clears, shifts in a keyed value, or decrements
// with borrow, reloading WRAP when it borrows from 0.
module cook_time_countdown_bcd_down_digit
    import cook_time_countdown_pkg::*;
#(
    parameter logic [3:0] WRAP = BcdMax
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       dec_en,
    input  logic       borrow_in,
    input  logic       shift_en,
    input  logic [3:0] shift_val,
    input  logic       clr,
    output logic [3:0] q,
    output logic       borrow_out
);

    logic [3:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (shift_en) begin
            q_d = shift_val;
        end else if (dec_en && borrow_in) begin
            q_d = (q_q == 4'd0) ? WRAP : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = borrow_in && (q_q == 4'd0);

endmodule

// File: rtl/cook_time_countdown.sv
// MM:SS cook timer: keyed digits shift in from the right, then count down once per
// 1 Hz tick with a one-cycle done pulse on reaching 00:00.
module cook_time_countdown
    import cook_time_countdown_pkg::*;
#(
    parameter int unsigned SEC_TENS_WRAP = SecTensWrapDef,
    parameter bit          TICK_IS_PULSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  clear,
    cook_time_countdown_if.slave  bus
);

    state_e     state_d, state_q;
    logic       pgt_q;
    logic       done_d, done_q;
    logic       tick;
    logic       load_ok;
    logic       dec_en, shift_en, clr_digits;
    logic       time_zero, last_sec;
    logic [3:0] dig       [4];
    logic [3:0] shift_src [4];
    logic [4:0] borrow;

    assign tick    = TICK_IS_PULSE ? bus.pgt_1hz : (bus.pgt_1hz && !pgt_q);
    assign load_ok = bus.load && bcd_valid(bus.digit);

    // sec_ones always borrows on a decrement, so the chain's final borrow means 00:00.
    assign borrow[0] = 1'b1;
    assign time_zero = borrow[4];
    assign last_sec  = (dig[0] == 4'd1) && (dig[1] == 4'd0) && (dig[2] == 4'd0) &&
                       (dig[3] == 4'd0);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam logic [3:0] Wrap = (i == 1) ? 4'(SEC_TENS_WRAP) : BcdMax;

        if (i == 0) begin : g_src_key
            assign shift_src[i] = bus.digit;
        end else begin : g_src_prev
            assign shift_src[i] = dig[i-1];
        end

        cook_time_countdown_bcd_down_digit #(
            .WRAP (Wrap)
        ) u_digit (
            .clk        (clk),
            .clear      (clear),
            .dec_en     (dec_en),
            .borrow_in  (borrow[i]),
            .shift_en   (shift_en),
            .shift_val  (shift_src[i]),
            .clr        (clr_digits),
            .q          (dig[i]),
            .borrow_out (borrow[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= StIdle;
            pgt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pgt_q   <= bus.pgt_1hz;
            done_q  <= done_d;
        end
    end

    // A keyed digit in IDLE takes precedence over start; start is re-evaluated next press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!bus.stop && !load_ok && bus.start && !time_zero) state_d = StRun;
            end
            StRun: begin
                if (bus.stop)                state_d = StPause;
                else if (tick && last_sec)   state_d = StDone;
            end
            StPause: begin
                if (bus.stop)       state_d = StIdle;
                else if (bus.start) state_d = StRun;
            end
            StDone: begin
                if (bus.stop || load_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dec_en     = 1'b0;
        shift_en   = 1'b0;
        clr_digits = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (bus.stop)     clr_digits = 1'b1;
                else if (load_ok) shift_en   = 1'b1;
            end
            StRun: begin
                if (!bus.stop && tick) begin
                    dec_en = 1'b1;
                    done_d = last_sec;
                end
            end
            StPause: begin
                if (bus.stop) clr_digits = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sec_ones = dig[0];
    assign bus.sec_tens = dig[1];
    assign bus.min_ones = dig[2];
    assign bus.min_tens = dig[3];
    assign bus.running  = (state_q == StRun);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_cook_time_countdown.sv
// Directed bench for the cook-time countdown: keypad entry, countdown, pause/resume,
// completion pulse and clear, each checked against hand-computed MM:SS values.
module tb_cook_time_countdown;

    logic clk;
    logic clear;
    int   n_total;
    int   n_bad;

    cook_time_countdown_if bus ();

    cook_time_countdown u_dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mmss();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        bus.load  = 1'b1;
        bus.digit = d;
        step();
        bus.load  = 1'b0;
        bus.digit = 4'd0;
    endtask

    task automatic tick();
        bus.pgt_1hz = 1'b1;
        step();
        bus.pgt_1hz = 1'b0;
        step();
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic press_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    initial begin
        int done_seen;
        n_total     = 0;
        n_bad       = 0;
        clear       = 1'b1;
        bus.load    = 1'b0;
        bus.digit   = 4'd0;
        bus.pgt_1hz = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        step();
        step();
        clear = 1'b0;
        check_eq("reset_time", mmss(), 16'h0000);
        check_eq("reset_running", 16'(bus.running), 16'h0);
        check_eq("reset_done", 16'(bus.done), 16'h0);

        // Entry: digits shift in from the right; non-BCD key ignored.
        key(4'd1);
        check_eq("load_first", mmss(), 16'h0001);
        key(4'd3);
        key(4'd0);
        check_eq("load_0130", mmss(), 16'h0130);
        key(4'hC);
        check_eq("load_invalid", mmss(), 16'h0130);

        // Countdown with seconds and minutes borrow.
        press_start();
        check_eq("start_running", 16'(bus.running), 16'h1);
        tick();
        check_eq("tick_0129", mmss(), 16'h0129);
        done_seen = 0;
        for (int i = 0; i < 29; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_eq("tick_0100", mmss(), 16'h0100);
        tick();
        check_eq("tick_0059", mmss(), 16'h0059);
        check_eq("no_early_done", 16'(done_seen), 16'h0);

        // Pause then cancel.
        press_stop();
        check_eq("pause_hold", mmss(), 16'h0059);
        check_eq("pause_not_running", 16'(bus.running), 16'h0);
        tick();
        check_eq("pause_ignores_tick", mmss(), 16'h0059);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_eq("pause_stop_wins", mmss(), 16'h0000);
        check_eq("pause_stop_idle", 16'(bus.running), 16'h0);

        // Completion: 00:02 -> 00:00 with a single-cycle done pulse.
        key(4'd2);
        press_start();
        tick();
        check_eq("tick_0001", mmss(), 16'h0001);
        check_eq("done_low_at_0001", 16'(bus.done), 16'h0);
        bus.pgt_1hz = 1'b1;
        step();
        check_eq("reach_0000", mmss(), 16'h0000);
        check_eq("done_pulse", 16'(bus.done), 16'h1);
        check_eq("done_not_running", 16'(bus.running), 16'h0);
        bus.pgt_1hz = 1'b0;
        step();
        check_eq("done_one_cycle", 16'(bus.done), 16'h0);

        // DONE: start ignored, keyed digit returns to IDLE with 00:05.
        press_start();
        check_eq("done_start_ignored", 16'(bus.running), 16'h0);
        key(4'd5);
        check_eq("done_load_0005", mmss(), 16'h0005);
        check_eq("done_load_idle", 16'(bus.running), 16'h0);

        // RUN: stop beats a simultaneous tick; resume; stop twice clears.
        press_start();
        bus.pgt_1hz = 1'b1;
        bus.stop    = 1'b1;
        step();
        bus.pgt_1hz = 1'b0;
        bus.stop    = 1'b0;
        step();
        check_eq("stop_beats_tick", mmss(), 16'h0005);
        check_eq("stop_to_pause", 16'(bus.running), 16'h0);
        press_start();
        check_eq("resume_running", 16'(bus.running), 16'h1);
        tick();
        check_eq("resume_tick", mmss(), 16'h0004);
        press_stop();
        press_stop();
        check_eq("stop_twice_time", mmss(), 16'h0000);
        check_eq("stop_twice_idle", 16'(bus.running), 16'h0);

        // Start with 00:00 stays idle; load+start shifts only.
        press_start();
        check_eq("start_zero_idle", 16'(bus.running), 16'h0);
        bus.start = 1'b1;
        key(4'd3);
        bus.start = 1'b0;
        check_eq("load_start_shift", mmss(), 16'h0003);
        check_eq("load_start_no_run", 16'(bus.running), 16'h0);
        press_stop();

        // Clear mid-RUN at 00:45.
        key(4'd4);
        key(4'd5);
        press_start();
        check_eq("pre_clear_0045", mmss(), 16'h0045);
        clear = 1'b1;
        bus.start = 1'b1;
        step();
        clear = 1'b0;
        bus.start = 1'b0;
        check_eq("clear_time", mmss(), 16'h0000);
        check_eq("clear_running", 16'(bus.running), 16'h0);
        check_eq("clear_done", 16'(bus.done), 16'h0);

        // Held level timebase decrements exactly once.
        key(4'd1);
        key(4'd0);
        press_start();
        bus.pgt_1hz = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.pgt_1hz = 1'b0;
        step();
        check_eq("held_tick_once", mmss(), 16'h0009);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
